// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, result codes and command bytes for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        SETUP,
        WAIT_DEV,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        FAIL
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_START_TO = 2'b01;
    localparam logic [1:0] ERR_XFER_TO  = 2'b10;
    localparam logic [1:0] ERR_NO_ACK   = 2'b11;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// rtl/ps2_line_cond.sv - synchronizer, glitch filter and falling-edge detector for one PS/2 line
module ps2_line_cond #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is taken only after FILTER_LEN consecutive samples disagree with the current one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= line_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = level_prev_q & ~level_q;

endmodule

// File: rtl/ps2_cmd_tx.sv
// rtl/ps2_cmd_tx.sv - PS/2 host-to-device command transmitter with request-to-send and ACK check
module ps2_cmd_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 250,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic [1:0] err_code
);

    localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_B = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_T + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [8:0]       shift_q, shift_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic [1:0]       err_q, err_d;

    logic clk_level, clk_fall, dat_level;

    ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_clk_cond (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_dat_cond (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_dat_in),
        .level_o (dat_level),
        .fall_o  ()
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        edge_d   = edge_q;
        shift_d  = shift_q;
        dat_oe_d = dat_oe_q;
        ack_ok_d = ack_ok_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    shift_d  = {odd_parity(cmd_data), cmd_data};
                    edge_d   = '0;
                    dat_oe_d = 1'b0;
                    ack_ok_d = 1'b0;
                    err_d    = ERR_NONE;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_DEV;
                end
            end
            WAIT_DEV: begin
                if (clk_fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = shift_q >> 1;
                    edge_d   = 4'd1;
                    cnt_d    = '0;
                    state_d  = SEND;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d   = ERR_START_TO;
                    state_d = FAIL;
                end
            end
            SEND: begin
                // Timer keeps running into ACK: one budget covers fall 1 through the ACK sample.
                if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
                    err_d   = ERR_XFER_TO;
                    state_d = FAIL;
                end else if (clk_fall) begin
                    edge_d = edge_q + 1'b1;
                    if (edge_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else begin
                        dat_oe_d = ~shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            ACK: begin
                if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
                    err_d   = ERR_XFER_TO;
                    state_d = FAIL;
                end else if (clk_fall) begin
                    edge_d = edge_q + 1'b1;
                    if (!dat_level) begin
                        ack_ok_d = 1'b1;
                        state_d  = WAIT_IDLE;
                    end else begin
                        err_d   = ERR_NO_ACK;
                        state_d = FAIL;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (clk_level && dat_level) begin
                    state_d = DONE;
                end
            end
            DONE, FAIL: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            shift_q  <= '0;
            dat_oe_q <= 1'b0;
            ack_ok_q <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            shift_q  <= shift_d;
            dat_oe_q <= dat_oe_d;
            ack_ok_q <= ack_ok_d;
            err_q    <= err_d;
        end
    end

    // Line enables decode straight from state so FAIL and reset release the bus at once.
    always_comb begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        unique case (state_q)
            INHIBIT:  ps2_clk_oe = 1'b1;
            SETUP: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
            end
            WAIT_DEV: ps2_dat_oe = 1'b1;
            SEND:     ps2_dat_oe = dat_oe_q;
            default: begin
                ps2_clk_oe = 1'b0;
                ps2_dat_oe = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) || (state_q == FAIL);
    assign ack_ok    = ack_ok_q;
    assign err_code  = err_q;

endmodule
